approx_mult_pipe: RTL and testbench
===================================

APPROX_MULT_PIPE -- requirements
Module: approx_mult_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 SHALL have parameter APPROX_COLS, default 6, number of low product columns computed approximately; legal range 0..WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand beat offered.
REQ-006 SHALL have port in_ready  output  1  block accepts operand beat this cycle.
REQ-007 SHALL have port a  input  WIDTH  signed multiplicand, two's complement.
REQ-008 SHALL have port b  input  WIDTH  signed multiplier, two's complement.
REQ-009 SHALL have port approx_en  input  1  per-beat mode: 1 approximate, 0 exact.
REQ-010 SHALL have port out_valid  output  1  result beat present.
REQ-011 SHALL have port out_ready  input  1  downstream accepts result beat.
REQ-012 SHALL have port y  output  2*WIDTH  signed product.
REQ-013 SHALL have port out_approx  output  1  approx_en of the beat carried by y.

Function
REQ-014 SHALL accept a beat when in_valid & in_ready, and deliver a beat when out_valid & out_ready.
REQ-015 SHALL compute exact mode as y = a*b, full 2*WIDTH signed result, no overflow possible.
REQ-016 SHALL compute approximate mode as y = (a*b - L) + O, where:
- L = sum of a[i]&b[j] * 2^(i+j) over all i+j < APPROX_COLS;
- O[c] = OR of a[i]&b[j] over i+j = c, for c < APPROX_COLS;
- O = 0 elsewhere, so no carry out of the low columns.
REQ-017 SHALL make approximate mode equal exact mode when APPROX_COLS = 0.
REQ-018 SHALL form partial products using Baugh-Wooley signed handling (inverted sign-row/column terms plus constant ones) so that REQ-015 holds at every operand corner.
REQ-019 SHALL be a 2-stage pipeline:
- stage 1: partial-product generation, low-column OR and reduction to two rows, registered;
- stage 2: final carry-propagate add, registered into y.
REQ-020 SHALL have a latency of exactly 2 cycles from acceptance to out_valid when out_ready is held high.
REQ-021 SHALL sustain one beat per cycle when out_ready is held high.
REQ-022 SHALL stall each stage only when its downstream register is occupied and not draining:
- in_ready = ~s1_valid | s1_advance;
- s1_advance = ~s2_valid | out_ready.
REQ-023 SHALL hold y and out_approx stable while out_valid & ~out_ready.
REQ-024 SHALL let in_ready depend combinationally only on out_ready and internal state, never on in_valid.
REQ-025 SHALL handle simultaneous output drain and input accept in the same cycle with no bubble and no beat loss.
REQ-026 SHALL deliver beats in acceptance order; no beat may be dropped or duplicated.

Reset
REQ-027 SHALL clear all stage valid flags when rst is asserted, with out_valid = 0 immediately and in_ready = 1 in the first cycle after rst deasserts.
REQ-028 SHALL reset y to 0 and out_approx to 0.
REQ-029 SHALL discard any in-flight beats when reset is asserted mid-operation; none emerge afterwards.

Structure
REQ-030 SHALL place default WIDTH/APPROX_COLS constants and a stage-1 payload struct (sum row, carry row, mode bit) in package approx_mult_pkg.
REQ-031 SHALL contain one combinational sub-module, approx_mult_reduce, performing stage-1 partial-product generation, low-column OR and row reduction.

Verification (WIDTH=8, APPROX_COLS=6)
REQ-032 SHALL check: a=7, b=7, approx_en=1 -> y=31 (0x001F); with approx_en=0 -> y=49.
REQ-033 SHALL check: a=-1, b=-1, approx_en=1 -> y=-257 (0xFEFF); exact -> y=1.
REQ-034 SHALL check: a=-128, b=-128 in both modes -> y=16384 (0x4000); a=-128, b=127 exact -> y=-16256 (0xC080).
REQ-035 SHALL check: 10 back-to-back beats with out_ready=1 -> out_valid first seen 2 cycles after the first accept, then 10 consecutive valid cycles.
REQ-036 SHALL check: out_ready low for 5 cycles with in_valid high -> exactly 2 beats held, in_ready low, y stable; on release, all beats appear in order with no loss.
REQ-037 SHALL check: rst pulsed while 2 beats are in flight -> out_valid=0 at once, y=0, no stale beat afterwards; plus 10k random beats versus the REQ-015/REQ-016 golden model.

Source files
------------

// File: rtl/approx_mult_pkg.sv
// approx_mult_pkg: shared constants and stage-1 payload for the approximate multiplier
package approx_mult_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_APPROX_COLS = 6;
    localparam int MAX_WIDTH = 32;
    // Rows are sized for the widest legal operand; narrower instances use the low 2*WIDTH bits.
    typedef struct packed {
        logic [2*MAX_WIDTH-1:0] sum;
        logic [2*MAX_WIDTH-1:0] carry;
        logic approx;
    } s1_t;
endpackage

// File: rtl/approx_mult_if.sv
// approx_mult_if: operand/result valid-ready bus of the approximate multiplier
interface approx_mult_if
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic in_valid, in_ready, approx_en;
    logic out_valid, out_ready, out_approx;
    logic [WIDTH-1:0] a, b;
    logic [2*WIDTH-1:0] y;
    modport master (
        output in_valid, a, b, approx_en, out_ready,
        input in_ready, out_valid, y, out_approx
    );
    modport slave (
        input in_valid, a, b, approx_en, out_ready,
        output in_ready, out_valid, y, out_approx
    );
endinterface

// File: rtl/approx_mult_reduce.sv
// approx_mult_reduce: Baugh-Wooley partial products, low-column OR and carry-save reduction to two rows
module approx_mult_reduce
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int APPROX_COLS = DEF_APPROX_COLS
) (
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic approx_en,
    output s1_t pay
);
    localparam int PW = 2 * WIDTH;
    localparam logic [WIDTH-1:0] INV_ROW = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] INV_TOP = {1'b0, {(WIDTH-1){1'b1}}};
    logic [WIDTH-1:0] pp;
    logic [PW-1:0] low, row, o, s, c, t;
    always_comb begin
        low = approx_en ? ({PW{1'b1}} >> (PW - APPROX_COLS)) : '0;
        pp = '0;
        row = '0;
        o = '0;
        c = '0;
        // Baugh-Wooley correction constants sit at columns WIDTH and 2*WIDTH-1.
        s = (PW'(1) << WIDTH) | (PW'(1) << (PW - 1));
        for (int j = 0; j < WIDTH; j++) begin
            pp = (a & {WIDTH{b[j]}}) ^ ((j == WIDTH - 1) ? INV_TOP : INV_ROW);
            row = PW'(pp) << j;
            o = o | (row & low);
            row = row & ~low;
            t = s ^ c ^ row;
            c = ((s & c) | (s & row) | (c & row)) << 1;
            s = t;
        end
        t = s ^ c ^ o;
        c = ((s & c) | (s & o) | (c & o)) << 1;
        s = t;
        pay = '0;
        pay.sum[PW-1:0] = s;
        pay.carry[PW-1:0] = c;
        pay.approx = approx_en;
    end
endmodule

// File: rtl/approx_mult_pipe.sv
// approx_mult_pipe: 2-stage valid/ready pipelined signed multiplier with optional low-column approximation
module approx_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int APPROX_COLS = DEF_APPROX_COLS
) (
    input logic clk,
    input logic rst,
    approx_mult_if.slave bus
);
    s1_t s1_d, s1_q;
    logic s1_valid, s2_valid, s1_advance, unused_hi;
    approx_mult_reduce #(.WIDTH(WIDTH), .APPROX_COLS(APPROX_COLS)) u_reduce (
        .a(bus.a),
        .b(bus.b),
        .approx_en(bus.approx_en),
        .pay(s1_d)
    );
    assign s1_advance = ~s2_valid | bus.out_ready;
    assign bus.in_ready = ~s1_valid | s1_advance;
    assign bus.out_valid = s2_valid;
    assign unused_hi = ^{s1_q.sum >> (2*WIDTH), s1_q.carry >> (2*WIDTH)};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            bus.y <= '0;
            bus.out_approx <= 1'b0;
        end else begin
            if (bus.in_ready) s1_valid <= bus.in_valid;
            if (s1_advance) s2_valid <= s1_valid;
            if (s1_advance && s1_valid) begin
                bus.y <= s1_q.sum[2*WIDTH-1:0] + s1_q.carry[2*WIDTH-1:0];
                bus.out_approx <= s1_q.approx;
            end
        end
    end
    always_ff @(posedge clk)
        if (bus.in_valid && bus.in_ready) s1_q <= s1_d;
endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb_approx_mult_pipe: directed corners, flow-control scenarios and random beats against an arithmetic model
module tb_approx_mult_pipe;
    localparam int W = 8;
    localparam int C = 6;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;
    int accepted = 0;
    logic [16:0] sb[$];
    approx_mult_if #(.WIDTH(W)) bus ();
    approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(C)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b, input logic ap);
        int p, l, o;
        p = int'($signed(a)) * int'($signed(b));
        l = 0;
        o = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < W; j++)
                if (ap && i + j < C && a[i] && b[j]) begin
                    l += 1 << (i + j);
                    o |= 1 << (i + j);
                end
        return 16'(p - l + o);
    endfunction

    function automatic logic [7:0] pick();
        int r;
        r = int'($urandom_range(0, 7));
        return r == 0 ? 8'h80 : r == 1 ? 8'h7f : r == 2 ? 8'hff : r == 3 ? 8'h00 : 8'($urandom);
    endfunction

    always @(negedge clk) begin
        if (rst) sb.delete();
        else begin
            if (bus.out_valid && bus.out_ready) begin
                check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) check("beat", 32'({bus.out_approx, bus.y}), 32'(sb.pop_front()));
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back({bus.approx_en, model(bus.a, bus.b, bus.approx_en)});
                accepted++;
            end
        end
    end

    task automatic one(input logic [7:0] a, input logic [7:0] b, input logic ap, input logic [15:0] exp, input string tag);
        bus.a = a;
        bus.b = b;
        bus.approx_en = ap;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        for (int n = 0; n < 8 && !bus.out_valid; n++) @(negedge clk);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check(tag, 32'(bus.y), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] vv;
        logic ir[5];
        logic ov[5];
        logic [15:0] yy[5];
        logic any_valid;
        int first, acc, start;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.approx_en = 1'b0;
        bus.out_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_out_approx", 32'(bus.out_approx), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        one(8'd7, 8'd7, 1'b1, 16'h001F, "7x7_approx");
        one(8'd7, 8'd7, 1'b0, 16'd49, "7x7_exact");
        one(8'hff, 8'hff, 1'b1, 16'hFEFF, "m1xm1_approx");
        one(8'hff, 8'hff, 1'b0, 16'h0001, "m1xm1_exact");
        one(8'h80, 8'h80, 1'b1, 16'h4000, "m128sq_approx");
        one(8'h80, 8'h80, 1'b0, 16'h4000, "m128sq_exact");
        one(8'h80, 8'h7f, 1'b0, 16'hC080, "m128x127_exact");

        vv = '0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            bus.in_valid = (k < 10);
            bus.a = pick();
            bus.b = pick();
            bus.approx_en = 1'($urandom);
            @(negedge clk);
            vv[k] = bus.out_valid;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        first = -1;
        for (int k = 15; k >= 0; k--) if (vv[k]) first = k;
        check("b2b_first", 32'(first), 32'd2);
        check("b2b_pattern", 32'(vv), 32'h0FFC);

        acc = 0;
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        bus.a = pick();
        bus.b = pick();
        bus.approx_en = 1'($urandom);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            ir[k] = bus.in_ready;
            ov[k] = bus.out_valid;
            yy[k] = bus.y;
            if (bus.in_ready) acc++;
            @(posedge clk);
            #1;
            if (ir[k]) begin
                bus.a = pick();
                bus.b = pick();
                bus.approx_en = 1'($urandom);
            end
        end
        check("stall_held", 32'(acc), 32'd2);
        check("stall_in_ready", 32'(ir[4]), 32'd0);
        check("stall_out_valid", 32'(ov[4]), 32'd1);
        check("stall_y_stable", 32'(yy[4]), 32'(yy[2]));
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("stall_drain", 32'(sb.size()), 32'd0);

        bus.in_valid = 1'b1;
        bus.a = 8'd3;
        bus.b = 8'd5;
        @(posedge clk);
        #1 bus.a = 8'h81;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        check("inflight_valid", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_y", 32'(bus.y), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        any_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            any_valid |= bus.out_valid;
        end
        check("midrst_no_stale", 32'(any_valid), 32'd0);
        @(posedge clk);
        #1;

        start = accepted;
        for (int n = 0; n < 40000 && accepted - start < 10000; n++) begin
            bus.in_valid = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.a = pick();
            bus.b = pick();
            bus.approx_en = 1'($urandom);
            @(posedge clk);
            #1;
        end
        check("rand_count", 32'(accepted - start >= 10000), 32'd1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rand_drain", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
